sprite_blitter: RTL and testbench

Command-driven writer that copies a rectangular sprite from a source sprite memory into the frame VRAM write port. Transparent pixels are skipped, and each pixel is clipped to the visible HSIZE×VSIZE area. Optional horizontal and vertical flips are applied. The block is the producer-side counterpart of the layer/transformer read path: it generates the same row-major addresses and flip mapping, but drives writes instead of scan-out reads.

---
 rtl/sprite_blitter.sv | 206 ++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter
//  Description : Copies a rectangular sprite from source memory into the frame
//                VRAM write port with colour-key skip, clipping and flips.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
    parameter int                     HWIDTH     = 12,
    parameter int                     VWIDTH     = 12,
    parameter int                     DATA_WIDTH = 13,
    parameter int                     SWIDTH     = 15,
    parameter int                     AWIDTH     = 19,
    parameter int                     HSIZE      = 640,
    parameter int                     VSIZE      = 480,
    parameter logic [DATA_WIDTH-1:0]  KEY        = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SWIDTH-1:0]       cmd_src,
    input  logic [HWIDTH-1:0]       cmd_x,
    input  logic [VWIDTH-1:0]       cmd_y,
    input  logic [HWIDTH-1:0]       cmd_w,
    input  logic [VWIDTH-1:0]       cmd_h,
    input  logic                    cmd_hflip,
    input  logic                    cmd_vflip,
    output logic [SWIDTH-1:0]       src_addr,
    output logic                    src_en,
    input  logic [DATA_WIDTH-1:0]   src_data,
    output logic [AWIDTH-1:0]       dst_addr,
    output logic [DATA_WIDTH-1:0]   dst_data,
    output logic                    dst_we,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [HWIDTH-1:0]        c_one_h   = 1;
    localparam logic [VWIDTH-1:0]        c_one_v   = 1;
    localparam logic signed [HWIDTH:0]   c_hsize_s = HSIZE[HWIDTH:0];
    localparam logic signed [VWIDTH:0]   c_vsize_s = VSIZE[VWIDTH:0];
    localparam logic [AWIDTH-1:0]        c_hsize_a = HSIZE[AWIDTH-1:0];

    state_t                 state_q, state_d;
    logic [SWIDTH-1:0]      src_base_q, src_base_d;
    logic [HWIDTH-1:0]      x_q, x_d;
    logic [VWIDTH-1:0]      y_q, y_d;
    logic [HWIDTH-1:0]      w_q, w_d;
    logic [VWIDTH-1:0]      h_q, h_d;
    logic                   hflip_q, hflip_d;
    logic                   vflip_q, vflip_d;
    logic [HWIDTH-1:0]      col_q, col_d;
    logic [VWIDTH-1:0]      row_q, row_d;
    logic                   src_en_q, src_en_d;
    logic [SWIDTH-1:0]      src_addr_q, src_addr_d;
    logic                   wr_valid_q, wr_valid_d;
    logic                   inb_q, inb_d;
    logic [AWIDTH-1:0]      dst_addr_q, dst_addr_d;
    logic                   done_q, done_d;

    logic                   w_accept;
    logic                   w_last_col;
    logic                   w_last_pix;
    logic [HWIDTH-1:0]      w_sc;
    logic [VWIDTH-1:0]      w_sr;
    logic signed [HWIDTH:0] w_px;
    logic signed [VWIDTH:0] w_py;

    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_last_col = (col_q == w_q - c_one_h);
    assign w_last_pix = w_last_col && (row_q == h_q - c_one_v);

    // Sequencer: latches the command and walks col/row for the pixel issued next cycle.
    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        hflip_d    = hflip_q;
        vflip_d    = vflip_q;
        col_d      = col_q;
        row_d      = row_q;
        src_en_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    src_base_d = cmd_src;
                    x_d        = cmd_x;
                    y_d        = cmd_y;
                    w_d        = cmd_w;
                    h_d        = cmd_h;
                    hflip_d    = cmd_hflip;
                    vflip_d    = cmd_vflip;
                    col_d      = '0;
                    row_d      = '0;
                    if ((cmd_w != '0) && (cmd_h != '0)) begin
                        state_d  = ST_RUN;
                        src_en_d = 1'b1;
                    end else begin
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_RUN: begin
                if (w_last_pix) begin
                    state_d = ST_DRAIN;
                end else begin
                    src_en_d = 1'b1;
                    if (w_last_col) begin
                        col_d = '0;
                        row_d = row_q + c_one_v;
                    end else begin
                        col_d = col_q + c_one_h;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Source address for the next issued pixel, flips applied in sprite space.
    always_comb begin
        w_sc       = hflip_d ? (w_d - c_one_h - col_d) : col_d;
        w_sr       = vflip_d ? (h_d - c_one_v - row_d) : row_d;
        src_addr_d = '0;
        if (src_en_d) begin
            src_addr_d = src_base_d + SWIDTH'(w_sr) * SWIDTH'(w_d) + SWIDTH'(w_sc);
        end
    end

    // Destination of the pixel being read this cycle, used when its data returns.
    always_comb begin
        w_px       = $signed({x_q[HWIDTH-1], x_q}) + $signed({1'b0, col_q});
        w_py       = $signed({y_q[VWIDTH-1], y_q}) + $signed({1'b0, row_q});
        inb_d      = !w_px[HWIDTH] && (w_px < c_hsize_s) &&
                     !w_py[VWIDTH] && (w_py < c_vsize_s);
        wr_valid_d = src_en_q;
        dst_addr_d = dst_addr_q;
        if (src_en_q) begin
            dst_addr_d = AWIDTH'(w_py[VWIDTH-1:0]) * c_hsize_a + AWIDTH'(w_px[HWIDTH-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_base_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            src_en_q   <= 1'b0;
            src_addr_q <= '0;
            wr_valid_q <= 1'b0;
            inb_q      <= 1'b0;
            dst_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            hflip_q    <= hflip_d;
            vflip_q    <= vflip_d;
            col_q      <= col_d;
            row_q      <= row_d;
            src_en_q   <= src_en_d;
            src_addr_q <= src_addr_d;
            wr_valid_q <= wr_valid_d;
            inb_q      <= inb_d;
            dst_addr_q <= dst_addr_d;
            done_q     <= done_d;
        end
    end

    assign src_addr = src_addr_q;
    assign src_en   = src_en_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = src_data;
    assign dst_we   = wr_valid_q && inb_q && (src_data != KEY);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_blitter
//  Description : Directed self-checking bench for sprite_blitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [14:0] cmd_src = '0;
    logic [11:0] cmd_x = '0;
    logic [11:0] cmd_y = '0;
    logic [11:0] cmd_w = '0;
    logic [11:0] cmd_h = '0;
    logic        cmd_hflip = 1'b0;
    logic        cmd_vflip = 1'b0;
    logic [14:0] src_addr;
    logic        src_en;
    logic [12:0] src_data = '0;
    logic [18:0] dst_addr;
    logic [12:0] dst_data;
    logic        dst_we;
    logic        busy;
    logic        done;

    sprite_blitter dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_hflip (cmd_hflip),
        .cmd_vflip (cmd_vflip),
        .src_addr  (src_addr),
        .src_en    (src_en),
        .src_data  (src_data),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_we    (dst_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [12:0] mem [0:255];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    int wa[$];
    int wd[$];
    int wc[$];
    int rd_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous source memory: data one cycle after the enable.
    always @(posedge clk) if (src_en) src_data <= mem[src_addr[7:0]];

    always @(negedge clk) begin
        if (dst_we === 1'b1) begin
            wa.push_back(int'(dst_addr));
            wd.push_back(int'(dst_data));
            wc.push_back(cyc);
        end
        if (src_en === 1'b1) rd_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wc.delete();
        rd_cnt   = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic drive_cmd(input int src, input int x, input int y, input int w,
                             input int h, input bit hf, input bit vf);
        cmd_src   = 15'(src);
        cmd_x     = 12'(x);
        cmd_y     = 12'(y);
        cmd_w     = 12'(w);
        cmd_h     = 12'(h);
        cmd_hflip = hf;
        cmd_vflip = vf;
        cmd_valid = 1'b1;
    endtask

    // Returns t0 such that the first cycle after the accept edge is cycle t0+1.
    task automatic wait_accept(input string tag, output int t0, output int nrdy);
        logic r;
        bit   ok;
        ok   = 0;
        nrdy = 0;
        t0   = -1000;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            r = cmd_ready;
            if (r !== 1'b1) nrdy++;
            @(posedge clk);
            #1;
            if (r === 1'b1) begin
                ok = 1;
                t0 = cyc - 1;
                break;
            end
        end
        if (!ok) chk({tag, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input int ea, input int ed, input int ec);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, wa[idx], ea);
            chk({tag, "_data"}, wd[idx], ed);
            chk({tag, "_cyc"},  wc[idx], ec);
        end else begin
            chk({tag, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0, t1, nr;
    int basic_addr [8] = '{3210, 3211, 3212, 3213, 3850, 3851, 3852, 3853};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = 13'(i + 1);
        mem[100] = 13'd1; mem[101] = 13'd2; mem[102] = 13'd3;
        mem[110] = 13'd0; mem[111] = 13'd7;
        for (int i = 0; i < 6; i++) mem[120 + i] = 13'(21 + i);
        mem[130] = 13'd9;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_src_en", src_en, 0);
        chk("rst_dst_we", dst_we, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_dst_addr", dst_addr, 0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // Basic copy
        drive_cmd(0, 10, 5, 4, 2, 0, 0);
        wait_accept("basic", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("basic");
        chk("basic_nwr", wa.size(), 8);
        for (int k = 0; k < 8; k++) chk_wr("basic_wr", k, basic_addr[k], k + 1, t0 + 2 + k);
        chk("basic_done_cyc", done_cyc, t0 + 10);
        chk("basic_busy_cycles", busy_cnt, 9);
        chk("basic_reads", rd_cnt, 8);
        @(negedge clk);
        chk("basic_done_pulse", done, 0);

        // Horizontal flip
        drive_cmd(100, 0, 0, 3, 1, 1, 0);
        wait_accept("hflip", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("hflip");
        chk("hflip_nwr", wa.size(), 3);
        chk_wr("hflip_wr0", 0, 0, 3, t0 + 2);
        chk_wr("hflip_wr1", 1, 1, 2, t0 + 3);
        chk_wr("hflip_wr2", 2, 2, 1, t0 + 4);

        // Vertical flip
        drive_cmd(100, 0, 0, 1, 3, 0, 1);
        wait_accept("vflip", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("vflip");
        chk("vflip_nwr", wa.size(), 3);
        chk_wr("vflip_wr0", 0, 0, 3, t0 + 2);
        chk_wr("vflip_wr1", 1, 640, 2, t0 + 3);
        chk_wr("vflip_wr2", 2, 1280, 1, t0 + 4);

        // Transparency
        drive_cmd(110, 0, 0, 2, 1, 0, 0);
        wait_accept("key", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("key");
        chk("key_nwr", wa.size(), 1);
        chk_wr("key_wr0", 0, 1, 7, t0 + 3);
        chk("key_done_cyc", done_cyc, t0 + 4);

        // Clipping at the bottom-left corner
        drive_cmd(120, -1, 479, 3, 2, 0, 0);
        wait_accept("clip", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("clip");
        chk("clip_nwr", wa.size(), 2);
        chk_wr("clip_wr0", 0, 306560, 22, t0 + 3);
        chk_wr("clip_wr1", 1, 306561, 23, t0 + 4);
        chk("clip_reads", rd_cnt, 6);
        chk("clip_done_cyc", done_cyc, t0 + 8);

        // Zero-size command with a second command held behind it
        drive_cmd(0, 0, 0, 0, 5, 0, 0);
        wait_accept("zero", t0, nr);
        clear_mon();
        drive_cmd(130, 2, 0, 1, 1, 0, 0);
        wait_accept("held", t1, nr);
        chk("held_not_ready_cycles", nr, 1);
        chk("held_accept_edge", t1, t0 + 2);
        chk("zero_done_cyc", done_cyc, t0 + 2);
        chk("zero_reads", rd_cnt, 0);
        chk("zero_nwr", wa.size(), 0);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("held");
        chk("held_nwr", wa.size(), 1);
        chk_wr("held_wr0", 0, 2, 9, t1 + 2);
        chk("held_done_cyc", done_cyc, t1 + 3);

        // Reset in the middle of a 4x4 command
        drive_cmd(0, 0, 0, 4, 4, 0, 0);
        wait_accept("abort", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_dst_we", dst_we, 0);
        chk("abort_done", done, 0);
        chk("abort_src_en", src_en, 0);
        chk("abort_src_addr", src_addr, 0);
        chk("abort_dst_addr", dst_addr, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("abort_nwr", wa.size(), 2);
        chk("abort_no_done", done_cnt, 0);

        // Normal command after the abort
        drive_cmd(0, 3, 1, 2, 1, 0, 0);
        wait_accept("post", t0, nr);
        cmd_valid = 1'b0;
        clear_mon();
        wait_done("post");
        chk("post_nwr", wa.size(), 2);
        chk_wr("post_wr0", 0, 643, 1, t0 + 2);
        chk_wr("post_wr1", 1, 644, 2, t0 + 3);
        chk("post_done_cyc", done_cyc, t0 + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
